// File: rtl/axil_regfile_pkg.sv
// Shared response codes and FSM encodings for the AXI4-Lite register file.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_DATA,
    WR_WAIT_ADDR,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_strb_reg.sv
// One DATA_WIDTH register with per-byte write enables and synchronous clear.
module axil_strb_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic [DATA_WIDTH-1:0]   d_i,
  output logic [DATA_WIDTH-1:0]   q_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (we_i && strb_i[b]) data_d[b*8 +: 8] = d_i[b*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file: NUM_REGS byte-strobed registers, optional
// read-only status slots, SLVERR on bad accesses and per-register write pulses.
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_hw_in,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic                  awready_q, wready_q, arready_q;
  logic [IDX_W-1:0]      awidx_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [NUM_REGS-1:0]   pulse_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      c_idx, r_idx;
  logic [DATA_WIDTH-1:0] c_data, rd_val;
  logic [STRB_W-1:0]     c_strb;
  logic                  wr_hit, rd_hit;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rd_slot;

  assign aw_hs = s_axi_awvalid && awready_q;
  assign w_hs  = s_axi_wvalid  && wready_q;
  assign ar_hs = s_axi_arvalid && arready_q;

  // Whichever half arrived first was latched; the other comes straight off the bus.
  assign c_idx  = (wr_state_q == WR_WAIT_DATA) ? awidx_q : s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign c_data = (wr_state_q == WR_WAIT_ADDR) ? wdata_q : s_axi_wdata;
  assign c_strb = (wr_state_q == WR_WAIT_ADDR) ? wstrb_q : s_axi_wstrb;
  assign r_idx  = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

  always_comb begin
    wr_state_d = wr_state_q;
    commit     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end else if (aw_hs) wr_state_d = WR_WAIT_DATA;
        else if (w_hs)      wr_state_d = WR_WAIT_ADDR;
      end
      WR_WAIT_DATA: if (w_hs) begin
        commit     = 1'b1;
        wr_state_d = WR_RESP;
      end
      WR_WAIT_ADDR: if (aw_hs) begin
        commit     = 1'b1;
        wr_state_d = WR_RESP;
      end
      WR_RESP: if (s_axi_bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (ar_hs)        rd_state_d = RD_DATA;
      RD_DATA: if (s_axi_rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_hit = 1'b0;
    wr_sel = '0;
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (c_idx == IDX_W'(i) && !RO_MASK[i]) begin
        wr_hit    = 1'b1;
        wr_sel[i] = commit;
      end
      if (r_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = rd_slot[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign rd_slot[i] = reg_hw_in[i*DATA_WIDTH +: DATA_WIDTH];
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      axil_strb_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
        .clk_i  (ACLK),
        .rst_i  (ARESET),
        .we_i   (wr_sel[i]),
        .strb_i (c_strb),
        .d_i    (c_data),
        .q_o    (rd_slot[i])
      );
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = rd_slot[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      pulse_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_ADDR);
      wready_q   <= (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_DATA);
      arready_q  <= (rd_state_d == RD_IDLE);
      pulse_q    <= wr_sel;
      if (aw_hs) awidx_q <= s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (rd_state_q == RD_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  // Protection bits, sub-word address bits and RW-slot status inputs carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, reg_hw_in,
                       s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axil_regfile.sv
// Directed plus randomized AXI4-Lite traffic against a word-array model of the register file.
module tb_axil_regfile;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [7:0] RO     = 8'h02;
  localparam int         NR     = 8;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [5:0]   s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0]   s_axi_awprot = '0, s_axi_arprot = '0;
  logic         s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic         s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic [31:0]  s_axi_wdata = '0;
  logic [3:0]   s_axi_wstrb = '0;
  logic         s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic [31:0]  s_axi_rdata;
  logic [255:0] reg_q, reg_hw_in;
  logic [7:0]   reg_wr_pulse;

  always #5 ACLK = ~ACLK;

  axil_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(8), .RO_MASK(RO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .reg_q(reg_q), .reg_hw_in(reg_hw_in), .reg_wr_pulse(reg_wr_pulse)
  );

  logic [31:0] mdl [NR];
  logic [31:0] hw  [NR];
  int pcnt_mdl [NR];
  int pcnt_dut [NR];
  int total = 0, passed = 0;

  always_comb for (int i = 0; i < NR; i++) reg_hw_in[i*32 +: 32] = hw[i];

  always @(posedge ACLK)
    for (int i = 0; i < NR; i++) if (reg_wr_pulse[i]) pcnt_dut[i]++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    total++;
    $error("FAIL %s handshake timeout", tag);
  endtask

  function automatic logic [31:0] mread(input logic [5:0] a);
    int idx = int'(a[5:2]);
    if (idx >= NR) return 32'h0;
    return RO[idx] ? hw[idx] : mdl[idx];
  endfunction

  function automatic logic [1:0] mresp(input logic [5:0] a);
    return (int'(a[5:2]) >= NR) ? SLVERR : OKAY;
  endfunction

  function automatic logic [255:0] mpack();
    logic [255:0] p = '0;
    for (int i = 0; i < NR; i++) p[i*32 +: 32] = RO[i] ? 32'h0 : mdl[i];
    return p;
  endfunction

  // bd < 0 leaves the response pending.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
    logic [1:0] er;
    logic [7:0] ep;
    logic hs_aw, hs_w, hs_b;
    int idx, t;
    idx = int'(a[5:2]);
    er = SLVERR;
    ep = '0;
    if (idx < NR && !RO[idx]) begin
      er = OKAY;
      ep[idx] = 1'b1;
      pcnt_mdl[idx]++;
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    fork
      begin
        int ta = 0;
        repeat (awd) begin @(posedge ACLK); #1; end
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        do begin hs_aw = s_axi_awready; @(posedge ACLK); #1; ta++; end while (!hs_aw && ta < 50);
        s_axi_awvalid = 1'b0;
        if (!hs_aw) timeout("aw");
      end
      begin
        int tw = 0;
        repeat (wd) begin @(posedge ACLK); #1; end
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        do begin hs_w = s_axi_wready; @(posedge ACLK); #1; tw++; end while (!hs_w && tw < 50);
        s_axi_wvalid = 1'b0;
        if (!hs_w) timeout("w");
      end
    join
    chk("bvalid_lat", 256'(s_axi_bvalid), 256'(1'b1));
    chk("bresp", 256'(s_axi_bresp), 256'(er));
    chk("wr_pulse", 256'(reg_wr_pulse), 256'(ep));
    chk("reg_q", reg_q, mpack());
    if (bd >= 0) begin
      repeat (bd) begin
        @(posedge ACLK); #1;
        chk("bresp_hold", 256'({s_axi_bvalid, s_axi_bresp}), 256'({1'b1, er}));
      end
      s_axi_bready = 1'b1;
      t = 0;
      do begin hs_b = s_axi_bvalid; @(posedge ACLK); #1; t++; end while (!hs_b && t < 50);
      s_axi_bready = 1'b0;
      if (!hs_b) timeout("b");
      chk("bvalid_clr", 256'(s_axi_bvalid), 256'(1'b0));
      chk("pulse_clr", 256'(reg_wr_pulse), 256'(8'h0));
    end
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input int rd);
    logic hs;
    int t = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    do begin hs = s_axi_arready; @(posedge ACLK); #1; t++; end while (!hs && t < 50);
    s_axi_arvalid = 1'b0;
    if (!hs) timeout("ar");
    chk("rvalid_lat", 256'(s_axi_rvalid), 256'(1'b1));
    chk("rdata", 256'(s_axi_rdata), 256'(ed));
    chk("rresp", 256'(s_axi_rresp), 256'(er));
    repeat (rd) begin
      @(posedge ACLK); #1;
      chk("rdata_hold", 256'({s_axi_rvalid, s_axi_rresp, s_axi_rdata}), 256'({1'b1, er, ed}));
    end
    s_axi_rready = 1'b1;
    t = 0;
    do begin hs = s_axi_rvalid; @(posedge ACLK); #1; t++; end while (!hs && t < 50);
    s_axi_rready = 1'b0;
    if (!hs) timeout("r");
    chk("rvalid_clr", 256'(s_axi_rvalid), 256'(1'b0));
  endtask

  task automatic chk_readies(input string tag, input logic v);
    chk(tag, 256'({s_axi_awready, s_axi_wready, s_axi_arready}), 256'({v, v, v}));
  endtask

  initial begin
    logic [5:0] a;
    logic [31:0] exp_d;
    for (int i = 0; i < NR; i++) begin
      mdl[i] = '0; pcnt_mdl[i] = 0; pcnt_dut[i] = 0; hw[i] = $urandom;
    end
    hw[1] = 32'hCAFE0001;

    repeat (3) begin @(posedge ACLK); #1; end
    chk_readies("rst_readies", 1'b0);
    chk("rst_outs", 256'({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_wr_pulse}), 256'(0));
    chk("rst_reg_q", reg_q, 256'(0));
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk_readies("post_rst_readies", 1'b1);

    for (int i = 0; i < 4; i++) axi_write(6'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(6'(i*4), mread(6'(i*4)), mresp(6'(i*4)), 0);

    axi_write(6'h00, 32'h11111111, 4'hF, 0, 0, 0);
    axi_write(6'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 1);
    axi_read(6'h00, 32'h11BB11DD, OKAY, 2);

    axi_write(6'h08, 32'h12345678, 4'hF, 0, 3, 0);
    axi_write(6'h0C, 32'h9ABCDEF0, 4'hF, 3, 0, 0);
    axi_read(6'h08, mread(6'h08), OKAY, 0);
    axi_read(6'h0C, mread(6'h0C), OKAY, 0);

    axi_write(6'h20, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(6'h20, 32'h0, SLVERR, 0);

    axi_write(6'h04, 32'h55555555, 4'hF, 0, 0, 0);
    axi_read(6'h04, 32'hCAFE0001, OKAY, 0);

    exp_d = mread(6'h10);
    fork
      axi_write(6'h10, 32'h0BADF00D, 4'hF, 0, 0, 0);
      axi_read(6'h10, exp_d, OKAY, 0);
    join
    axi_read(6'h10, mread(6'h10), OKAY, 0);

    for (int n = 0; n < 30; n++) begin
      a = 6'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, mread(a), mresp(a), $urandom_range(0, 2));
    end

    for (int i = 0; i < NR; i++) chk($sformatf("pulse_cnt%0d", i), 256'(pcnt_dut[i]), 256'(pcnt_mdl[i]));

    axi_write(6'h14, 32'hFEEDFACE, 4'hF, 0, 0, -1);
    repeat (5) begin
      @(posedge ACLK); #1;
      chk("bvalid_stall", 256'(s_axi_bvalid), 256'(1'b1));
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    chk("midrst_bvalid", 256'(s_axi_bvalid), 256'(1'b0));
    chk("midrst_reg_q", reg_q, 256'(0));
    chk_readies("midrst_readies", 1'b0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk_readies("midrst_post_readies", 1'b1);
    axi_write(6'h18, 32'h0C0FFEE0, 4'hF, 0, 0, 0);
    axi_read(6'h18, mread(6'h18), OKAY, 0);
    axi_read(6'h14, mread(6'h14), OKAY, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
